sum_window_acc: RTL and testbench
=================================

Name: sum_window_acc

Overview:
Downstream consumer of the ignore-filtered pairwise-sum stage: takes its (w+1)-bit sum output plus a valid strobe and aggregates n consecutive valid sums into one window result (total, max, min). The result is offered to the next stage through a valid/ready handshake. A registered FSM sequences accumulation, result hold and back-pressure, with sticky loss reporting.

Parameters:
w, 4, bit width of the upstream data input; incoming sums are w+1 bits
n, 4, samples per window; legal range 1 <= n <= 2^cw
cw, 4, window-count headroom bits; total is w+1+cw bits wide

Ports:
clk  input  1  clock; all state changes on posedge
rst_b  input  1  reset, asynchronous, active-high (one clock; reset is asynchronous and active-high)
s  input  w+1  sum sample from upstream stage
s_valid  input  1  s is a valid sample this cycle (sampled at posedge)
out_ready  input  1  consumer accepts the result this cycle
total  output  w+1+cw  sum of the n samples of the last completed window
max_s  output  w+1  largest sample of the last completed window
min_s  output  w+1  smallest sample of the last completed window
out_valid  output  1  result held and awaiting acceptance
busy  output  1  high when state != IDLE
lost  output  1  sticky: a sample was dropped due to back-pressure

Behaviour:
- Reset (async, immediate, not clock-gated): state IDLE; sample counter, internal accumulators, total, max_s, min_s all 0; out_valid, busy, lost 0. A partial window is discarded.
- Internal registers: cnt (samples taken in current window, 0..n-1), acc (w+1+cw bits), run_max, run_min.
- A sample counts only on a posedge with s_valid=1. Cycles with s_valid=0 change nothing, including cnt.
- States:
  - IDLE: s_valid -> start window (acc=s, run_max=run_min=s, cnt=1). Go to ACC, or straight to HOLD if n==1.
  - ACC: s_valid -> acc+=s, run_max=max, run_min=min, cnt+1. On the sample that makes n, go to HOLD.
  - HOLD: out_valid=1; total/max_s/min_s are stable. out_ready -> out_valid falls next edge, go to IDLE.
- Result load: on the same edge that takes the n-th sample, total/max_s/min_s load the values including that sample. out_valid is visible after that edge (latency 1 cycle from the n-th sample).
- The window-completing sum is computed as acc+s in full w+1+cw width; it never wraps for n <= 2^cw. Max/min comparisons are unsigned.
- Outputs total/max_s/min_s keep the last completed window until the next completion or reset; they are 0 before the first window.
- HOLD with s_valid=1, out_ready=0: sample dropped, lost<=1, result unchanged, state HOLD.
- HOLD with s_valid=1, out_ready=1 (simultaneous): result accepted, and the sample starts the next window (cnt=1, go to ACC; with n==1, reload result and stay HOLD, out_valid stays 1). No loss.
- lost is cleared only by reset.
- busy = (state != IDLE), registered state decode.

Test Plan:
- w=4,n=4: s_valid with s=7,10,5,11 on 4 consecutive edges, out_ready=0 -> after 4th edge out_valid=1, total=33, max_s=11, min_s=5, busy=1; s_valid gaps between samples change nothing.
- Continue HOLD, out_ready=0, s_valid with s=3 -> lost=1, total stays 33, out_valid stays 1; then out_ready=1, s_valid=0 -> next edge out_valid=0, busy=0, lost still 1.
- Simultaneous: in HOLD, out_ready=1 and s_valid with s=30 on the same edge, then s=30,30,30 -> first window accepted, new window completes with total=120, max_s=min_s=30; lost unchanged.
- Reset mid-window: after 2 samples (4,9), pulse rst_b between clock edges -> total/max_s/min_s/out_valid/busy/lost read 0 before the next posedge; then 1,2,3,4 -> total=10, max_s=4, min_s=1.
- Width stress, w=4,n=16,cw=4: 16 samples of 30 -> total=480 (no wrap in 9 bits).
- n=1: s=17 -> out_valid=1, total=17. Then out_ready=1 with s=5 -> out_valid stays 1, total=5.

Source files
------------

// File: rtl/sum_window_acc_if.sv
// Handshake bundle between the pairwise-sum stage, the window accumulator
// and the downstream consumer of window results.
interface sum_window_acc_if #(
    parameter int w  = 4,
    parameter int cw = 4
);
    logic [w:0]    s;
    logic          s_valid;
    logic          out_ready;
    logic [w+cw:0] total;
    logic [w:0]    max_s;
    logic [w:0]    min_s;
    logic          out_valid;
    logic          busy;
    logic          lost;

    // Upstream source / downstream consumer side
    modport master (
        output s, s_valid, out_ready,
        input  total, max_s, min_s, out_valid, busy, lost
    );

    // Accumulator side
    modport slave (
        input  s, s_valid, out_ready,
        output total, max_s, min_s, out_valid, busy, lost
    );
endinterface

// File: rtl/sum_window_acc.sv
// Window accumulator: folds n consecutive valid sums into total/max/min,
// holds the result behind a valid/ready handshake and flags dropped samples.
module sum_window_acc #(
    parameter int w  = 4,
    parameter int n  = 4,
    parameter int cw = 4
) (
    input logic             clk,
    input logic             rst_b,
    sum_window_acc_if.slave bus
);
    localparam int TW = w + 1 + cw;
    localparam logic [cw-1:0] LAST = cw'(n - 1);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t          state;
    logic [cw-1:0]   cnt;
    logic [TW-1:0]   acc;
    logic [w:0]      run_max;
    logic [w:0]      run_min;
    logic [TW-1:0]   total_q;
    logic [w:0]      max_q;
    logic [w:0]      min_q;
    logic            out_valid_q;
    logic            busy_q;
    logic            lost_q;

    logic [TW-1:0]   s_ext;
    logic [TW-1:0]   sum_next;
    logic [w:0]      max_next;
    logic [w:0]      min_next;

    // Running values including the current sample (unsigned compare, full-width add)
    always_comb begin
        s_ext    = TW'(bus.s);
        sum_next = acc + s_ext;
        max_next = (bus.s > run_max) ? bus.s : run_max;
        min_next = (bus.s < run_min) ? bus.s : run_min;
    end

    // Window sequencing, result hold and back-pressure with registered outputs
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            run_max     <= '0;
            run_min     <= '0;
            total_q     <= '0;
            max_q       <= '0;
            min_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (bus.s_valid) begin
                        acc     <= sum_next;
                        run_max <= max_next;
                        run_min <= min_next;
                        if (cnt == LAST) begin
                            cnt         <= '0;
                            total_q     <= sum_next;
                            max_q       <= max_next;
                            min_q       <= min_next;
                            out_valid_q <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            cnt <= cnt + cw'(1);
                        end
                    end
                end
                default: begin
                    // IDLE and HOLD-with-acceptance share the window-start path,
                    // so a sample arriving on the accepting edge is not lost.
                    if (state == HOLD && !bus.out_ready) begin
                        if (bus.s_valid) begin
                            lost_q <= 1'b1;
                        end
                    end else if (bus.s_valid) begin
                        acc     <= s_ext;
                        run_max <= bus.s;
                        run_min <= bus.s;
                        busy_q  <= 1'b1;
                        if (n == 1) begin
                            cnt         <= '0;
                            total_q     <= s_ext;
                            max_q       <= bus.s;
                            min_q       <= bus.s;
                            out_valid_q <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            cnt         <= cw'(1);
                            out_valid_q <= 1'b0;
                            state       <= ACC;
                        end
                    end else if (state == HOLD) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.total     = total_q;
    assign bus.max_s     = max_q;
    assign bus.min_s     = min_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.lost      = lost_q;
endmodule

// File: tb/tb_sum_window_acc.sv
// Bench for sum_window_acc: three instances (n=4, n=16, n=1) share one
// stimulus stream and are compared every cycle against a window model.
module tb_sum_window_acc;
    logic clk;
    logic rst_b;

    sum_window_acc_if #(.w(4), .cw(4)) if4  ();
    sum_window_acc_if #(.w(4), .cw(4)) if16 ();
    sum_window_acc_if #(.w(4), .cw(4)) if1  ();

    sum_window_acc #(.w(4), .n(4),  .cw(4)) u4  (.clk(clk), .rst_b(rst_b), .bus(if4));
    sum_window_acc #(.w(4), .n(16), .cw(4)) u16 (.clk(clk), .rst_b(rst_b), .bus(if16));
    sum_window_acc #(.w(4), .n(1),  .cw(4)) u1  (.clk(clk), .rst_b(rst_b), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model: samples collected into a buffer; result from plain arithmetic
    int nn [3] = '{4, 16, 1};
    int m_buf [3][16];
    int m_cnt [3];
    bit m_hold [3];
    bit m_lost [3];
    int m_total [3];
    int m_max [3];
    int m_min [3];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_hold[k] = 0; m_lost[k] = 0;
            m_total[k] = 0; m_max[k] = 0; m_min[k] = 0;
        end
    endtask

    task automatic model_step(input bit sv, input int sval, input bit rdy);
        for (int k = 0; k < 3; k++) begin
            if (m_hold[k] && !rdy) begin
                if (sv) m_lost[k] = 1;
            end else begin
                if (m_hold[k]) m_hold[k] = 0;
                if (sv) begin
                    m_buf[k][m_cnt[k]] = sval;
                    m_cnt[k]++;
                    if (m_cnt[k] == nn[k]) begin
                        int t, mx, mn;
                        t = 0; mx = 0; mn = 1 << 30;
                        for (int i = 0; i < nn[k]; i++) begin
                            t += m_buf[k][i];
                            if (m_buf[k][i] > mx) mx = m_buf[k][i];
                            if (m_buf[k][i] < mn) mn = m_buf[k][i];
                        end
                        m_total[k] = t; m_max[k] = mx; m_min[k] = mn;
                        m_hold[k] = 1;
                        m_cnt[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_inst(input int k, input logic ov, input logic bz, input logic ls,
                              input logic [8:0] tot, input logic [4:0] mx, input logic [4:0] mn);
        check($sformatf("n%0d.out_valid", nn[k]), int'(ov), int'(m_hold[k]));
        check($sformatf("n%0d.busy", nn[k]), int'(bz), int'(m_hold[k] || m_cnt[k] > 0));
        check($sformatf("n%0d.lost", nn[k]), int'(ls), int'(m_lost[k]));
        check($sformatf("n%0d.total", nn[k]), int'(tot), m_total[k]);
        check($sformatf("n%0d.max_s", nn[k]), int'(mx), m_max[k]);
        check($sformatf("n%0d.min_s", nn[k]), int'(mn), m_min[k]);
    endtask

    task automatic check_all();
        check_inst(0, if4.out_valid,  if4.busy,  if4.lost,  if4.total,  if4.max_s,  if4.min_s);
        check_inst(1, if16.out_valid, if16.busy, if16.lost, if16.total, if16.max_s, if16.min_s);
        check_inst(2, if1.out_valid,  if1.busy,  if1.lost,  if1.total,  if1.max_s,  if1.min_s);
    endtask

    task automatic drive(input bit sv, input logic [4:0] sval, input bit rdy);
        if4.s = sval;  if4.s_valid = sv;  if4.out_ready = rdy;
        if16.s = sval; if16.s_valid = sv; if16.out_ready = rdy;
        if1.s = sval;  if1.s_valid = sv;  if1.out_ready = rdy;
    endtask

    // One clock: inputs set away from the edge, model advanced, outputs checked
    task automatic cycle(input bit sv, input logic [4:0] sval, input bit rdy);
        drive(sv, sval, rdy);
        @(posedge clk);
        model_step(sv, int'(sval), rdy);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before the next edge
    task automatic pulse_reset();
        drive(1'b0, 5'd0, 1'b0);
        #1;
        rst_b = 1'b1;
        #1;
        model_reset();
        check_all();
        rst_b = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_b = 1'b1;
        drive(1'b0, 5'd0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst_b = 1'b0;

        // Basic window with idle gaps between samples
        cycle(1, 5'd7, 0);
        cycle(0, 5'd0, 0);
        cycle(1, 5'd10, 0);
        cycle(0, 5'd31, 0);
        cycle(1, 5'd5, 0);
        check("t1.ov_before_last", int'(if4.out_valid), 0);
        cycle(1, 5'd11, 0);
        check("t1.ov", int'(if4.out_valid), 1);
        check("t1.total", int'(if4.total), 33);
        check("t1.max", int'(if4.max_s), 11);
        check("t1.min", int'(if4.min_s), 5);
        check("t1.busy", int'(if4.busy), 1);

        // Dropped sample under back-pressure, then acceptance
        cycle(1, 5'd3, 0);
        check("t2.lost", int'(if4.lost), 1);
        check("t2.total_kept", int'(if4.total), 33);
        check("t2.ov_kept", int'(if4.out_valid), 1);
        cycle(0, 5'd0, 1);
        check("t2.ov_fall", int'(if4.out_valid), 0);
        check("t2.busy_fall", int'(if4.busy), 0);
        check("t2.lost_sticky", int'(if4.lost), 1);

        // Simultaneous accept and new-window start
        cycle(1, 5'd1, 0);
        cycle(1, 5'd2, 0);
        cycle(1, 5'd3, 0);
        cycle(1, 5'd4, 0);
        check("t3.first_total", int'(if4.total), 10);
        cycle(1, 5'd30, 1);
        check("t3.ov_after_accept", int'(if4.out_valid), 0);
        check("t3.busy_after_accept", int'(if4.busy), 1);
        cycle(1, 5'd30, 0);
        cycle(1, 5'd30, 0);
        cycle(1, 5'd30, 0);
        check("t3.total", int'(if4.total), 120);
        check("t3.max", int'(if4.max_s), 30);
        check("t3.min", int'(if4.min_s), 30);
        check("t3.lost_unchanged", int'(if4.lost), 1);

        // Reset in the middle of a window
        pulse_reset();
        cycle(1, 5'd4, 0);
        cycle(1, 5'd9, 0);
        pulse_reset();
        check("t4.total_zero", int'(if4.total), 0);
        check("t4.busy_zero", int'(if4.busy), 0);
        cycle(1, 5'd1, 0);
        cycle(1, 5'd2, 0);
        cycle(1, 5'd3, 0);
        cycle(1, 5'd4, 0);
        check("t4.total", int'(if4.total), 10);
        check("t4.max", int'(if4.max_s), 4);
        check("t4.min", int'(if4.min_s), 1);

        // Width stress on the 16-sample instance
        pulse_reset();
        for (int i = 0; i < 16; i++) cycle(1, 5'd30, 0);
        check("t5.total480", int'(if16.total), 480);
        check("t5.ov", int'(if16.out_valid), 1);

        // Single-sample windows
        pulse_reset();
        cycle(1, 5'd17, 0);
        check("t6.ov", int'(if1.out_valid), 1);
        check("t6.total", int'(if1.total), 17);
        cycle(1, 5'd5, 1);
        check("t6.ov_stays", int'(if1.out_valid), 1);
        check("t6.total_reload", int'(if1.total), 5);
        check("t6.lost", int'(if1.lost), 0);

        // Randomized traffic against the model, with occasional resets
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                cycle(bit'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)),
                      bit'($urandom_range(0, 3) != 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
